// File: rtl/count_dispatcher.sv
// Request FIFO in front of the 6-bit down-counter: pops one count at a time and
// issues it as a single-cycle load only when the counter reports done.
module count_dispatcher #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int HOLD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [DATA_W-1:0] req_count,
    output logic              req_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] cnt_din,
    output logic              cnt_ena,
    input  logic              cnt_oflag,
    output logic              done_pulse,
    output logic              busy,
    output logic [ADDR_W:0]   pending
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

    state_t              state;
    logic [HW-1:0]       hold_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     count;
    logic                full, empty, push, pop;
    logic [DATA_W-1:0]   head;

    assign full      = (count == (ADDR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign req_ready = !full && !rst;
    assign pending   = count;
    assign busy      = (state != S_IDLE) || !empty;

    // flush wins over both sides of the FIFO, including the FSM's pop
    assign push = req_valid && req_ready && !flush;
    assign pop  = (state == S_IDLE) && !empty && cnt_oflag && !flush;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= req_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        end
    end

    // After a load, cnt_oflag still shows the old "done" for a few cycles,
    // so HOLD masks it before RUN starts watching for completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            cnt_ena    <= 1'b0;
            cnt_din    <= '0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        if (head == '0) begin
                            done_pulse <= 1'b1;
                        end else begin
                            cnt_din <= head;
                            cnt_ena <= 1'b1;
                            state   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    cnt_ena  <= 1'b0;
                    hold_cnt <= HW'(HOLD - 1);
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_cnt == '0)
                        state <= S_RUN;
                    else
                        hold_cnt <= hold_cnt - HW'(1);
                end
                S_RUN: begin
                    if (cnt_oflag) begin
                        done_pulse <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_dispatcher.sv
// Randomized bench for count_dispatcher: a transaction-level model (request queue,
// in-flight job age) plus a down-counter model predicts every output each cycle.
module tb_count_dispatcher;

    localparam int DATA_W = 6;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int HOLD   = 2;
    localparam int CYCLES = 3000;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [DATA_W-1:0] req_count;
    logic              req_ready;
    logic              flush;
    logic [DATA_W-1:0] cnt_din;
    logic              cnt_ena;
    logic              cnt_oflag;
    logic              done_pulse;
    logic              busy;
    logic [ADDR_W:0]   pending;

    count_dispatcher #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_count(req_count),
        .req_ready(req_ready), .flush(flush), .cnt_din(cnt_din), .cnt_ena(cnt_ena),
        .cnt_oflag(cnt_oflag), .done_pulse(done_pulse), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: queued requests, one job in flight with its age in edges
    logic [DATA_W-1:0] q[$];
    bit                m_inflight;
    int                m_age;
    bit                m_ena, m_done;
    logic [DATA_W-1:0] m_din;
    int                ctr;
    int                n_ena, n_done;

    function automatic logic [DATA_W-1:0] pick_count();
        int r;
        r = $urandom_range(0, 99);
        if (r < 20)      return '0;
        else if (r < 70) return DATA_W'($urandom_range(1, 7));
        else if (r < 90) return DATA_W'($urandom_range(8, 20));
        else if (r < 95) return DATA_W'(63);
        else             return DATA_W'($urandom_range(21, 62));
    endfunction

    task automatic model_step();
        int  nctr;
        bit  ne, nd, can_push;
        logic [DATA_W-1:0] h;
        nctr = m_ena ? int'(m_din) : ((ctr > 0) ? ctr - 1 : 0);
        if (rst) begin
            q.delete();
            m_inflight = 0;
            m_age      = 0;
            m_ena      = 0;
            m_din      = '0;
            m_done     = 0;
        end else begin
            ne = 0;
            nd = 0;
            can_push = (q.size() < DEPTH);
            if (m_inflight) begin
                m_age++;
                // LOAD, HOLD cycles, then RUN samples the done flag
                if (m_age >= HOLD + 2 && cnt_oflag) begin
                    nd = 1;
                    m_inflight = 0;
                end
            end else if (!flush && q.size() > 0 && cnt_oflag) begin
                h = q.pop_front();
                if (h == '0) begin
                    nd = 1;
                end else begin
                    ne = 1;
                    m_din = h;
                    m_inflight = 1;
                    m_age = 0;
                end
            end
            if (flush)
                q.delete();
            else if (req_valid && can_push)
                q.push_back(req_count);
            m_ena  = ne;
            m_done = nd;
        end
        ctr = nctr;
    endtask

    initial begin
        bit exp_ready, force_busy;
        rst = 1'b1; req_valid = 1'b0; req_count = '0; flush = 1'b0; cnt_oflag = 1'b1;
        ctr = 0; m_inflight = 0; m_age = 0; m_ena = 0; m_din = '0; m_done = 0;
        n_ena = 0; n_done = 0;
        q.delete();
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            exp_ready = !rst && (q.size() < DEPTH);
            check("cnt_ena",    32'(cnt_ena),    32'(m_ena));
            check("cnt_din",    32'(cnt_din),    32'(m_din));
            check("done_pulse", 32'(done_pulse), 32'(m_done));
            check("pending",    32'(pending),    32'(q.size()));
            check("busy",       32'(busy),       32'(m_inflight || q.size() != 0));
            check("req_ready",  32'(req_ready),  32'(exp_ready));
            if (m_ena)  n_ena++;
            if (m_done) n_done++;

            // a stalled request stays on the bus unchanged until accepted
            if (!(req_valid && !exp_ready)) begin
                req_valid = ($urandom_range(0, 99) < 50);
                req_count = pick_count();
            end
            force_busy = (cyc >= 1000 && cyc < 1400 && (cyc % 200) < 120);
            flush = ($urandom_range(0, 99) < ((cyc < 1000) ? 2 : 5));
            rst   = (cyc < 5) || ($urandom_range(0, 199) < ((cyc < 1000) ? 1 : 3));
            cnt_oflag = force_busy ? 1'b0 : (ctr == 0);
            model_step();
        end

        check("ena_seen",  32'(n_ena > 10),  32'd1);
        check("done_seen", 32'(n_done > 10), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/count_dispatcher.md
Name: count_dispatcher

Overview:
- Upstream feeder for the team's 6-bit down-counter.
- Accepts count requests over a valid/ready interface and buffers them in a small FIFO.
- Issues each request to the counter as a one-cycle load (`cnt_din` + `cnt_ena`) only when the counter reports done (`cnt_oflag`=1).
- Flags completion of every request, which lets back-to-back count jobs queue without corrupting a count in progress.

Parameters:
- DATA_W, 6, width of a count value; matches the counter's `din`.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- ADDR_W, 2, log2(DEPTH).
- HOLD, 2, cycles after a load before `cnt_oflag` is trusted as "done"; must be at least 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_count  in  DATA_W  requested count value.
- req_ready  out  1  FIFO can accept; equals !full; forced 0 while rst=1.
- flush  in  1  synchronous clear of queued (not in-flight) requests.
- cnt_din  out  DATA_W  load value to counter `din`.
- cnt_ena  out  1  one-cycle load strobe to counter `ena`.
- cnt_oflag  in  1  counter done flag: 1 when count is 0; 0 while counting.
- done_pulse  out  1  one-cycle pulse per completed request, including zero-count requests.
- busy  out  1  (state != IDLE) or FIFO non-empty.
- pending  out  ADDR_W+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset values, on an edge with rst=1:
  - FIFO empty; `pending`=0; state=IDLE; hold counter=0.
  - `cnt_ena`=0; `cnt_din`=0; `done_pulse`=0; `busy`=0.
- Outputs:
  - All outputs are registered except `req_ready`, which is combinational from `full` and `rst`.
  - `busy` is combinational.
- FIFO:
  - Push when `req_valid` & `req_ready`.
  - Pop only by FSM in IDLE.
  - No bypass: a request pushed at edge k is poppable at edge k+1 at the earliest.
  - Push and pop in the same cycle are both performed; `pending` is unchanged.
  - Pointers wrap modulo DEPTH; full/empty are derived from an ADDR_W+1 occupancy count.
- flush=1:
  - Empties the FIFO at that edge and discards any simultaneous push.
  - Does not affect an in-flight request (state, `cnt_*`, `done_pulse`).
  - flush has priority over push and pop.
- FSM states are IDLE, LOAD, HOLD, RUN.
- IDLE:
  - If FIFO non-empty and `cnt_oflag`=1, pop the head.
  - Head==0: `done_pulse`<=1 next cycle; stay IDLE; no `cnt_ena`.
  - Head!=0: `cnt_din`<=head; `cnt_ena`<=1; go to LOAD.
  - If `cnt_oflag`=0 (counter busy from an external or pre-reset load), wait; do not pop.
- LOAD: `cnt_ena`<=0; `cnt_din` held; hold counter<=HOLD-1; go to HOLD. `cnt_ena` is therefore high exactly 1 cycle.
- HOLD:
  - Decrement the hold counter; ignore `cnt_oflag`.
  - At 0, go to RUN.
- RUN: when `cnt_oflag`=1, `done_pulse`<=1 for one cycle and go to IDLE.
- Latency:
  - Minimum gap between successive `cnt_ena` pulses is 3+HOLD cycles (IDLE→LOAD→HOLD…→RUN→IDLE).
  - The next pop can occur in the same cycle `done_pulse` is high.
- Arithmetic: `req_count` is stored unmodified; no saturation or range check; full DATA_W range 0..63 supported.
- Reset mid-operation:
  - All requests are dropped; `cnt_ena` is low from the next edge.
  - The counter itself is not reset. The dispatcher will not issue again until `cnt_oflag`=1, so an interrupted count finishes undisturbed.
- `req_valid` with `req_ready`=0: no push; the upstream holds the request; no loss.

Test Plan:
1. Reset, then push count 8 with `cnt_oflag`=1 → exactly one `cnt_ena` pulse with `cnt_din`=8 two edges after the push; `done_pulse` once, after the counter reaches 0 (within 8..8+HOLD+2 cycles of the ena); `pending` returns to 0.
2. Push 8, 16, 3, 5 back-to-back (req_valid held 4 cycles) → all accepted; `pending` peaks at 3–4; `cnt_ena` pulses carry 8, 16, 3, 5 in order; each issues only after the prior `done_pulse`; 4 `done_pulse`s total.
3. Fill FIFO (DEPTH=4) while the counter is held busy (`cnt_oflag` forced 0) → `req_ready`=0 with `pending`=4; a 5th request is stalled, not lost; release `cnt_oflag`=1 → `req_ready` rises and the 5th is accepted.
4. Push count 0 → no `cnt_ena`; `done_pulse` one cycle after the pop; then push count 1 → `cnt_ena` with `cnt_din`=1 and `done_pulse` after HOLD expires with `cnt_oflag`=1.
5. Push 16; after its `cnt_ena`, push 4 and 7, then assert flush one cycle → `pending`=0; the 16 run completes with one `done_pulse`; no further `cnt_ena`.
6. Assert rst during RUN of count 16 → next edge: `busy`=0, `pending`=0, `cnt_ena`=0; after rst, push 8 while `cnt_oflag` is still 0 → no issue until `cnt_oflag`=1, then `cnt_din`=8 is loaded.
